// File: rtl/sdr_tx_pkg.sv
// -----------------------------------------------------------------------------
// sdr_tx_pkg
// Shared types and helpers for the SDR transmit path.
//   state_t   : transmit FSM state (IDLE / FILL / RUN)
//   FS        : sigma-delta full scale at the default sample width
//   fs_of     : full scale for an arbitrary sample width (2**w)
//   lo_sign   : applies a 1-bit LO (+1 / -1) to a signed value
// -----------------------------------------------------------------------------
package sdr_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int IQ_W_DEF = 8;

  function automatic int fs_of(input int w);
    return 1 << w;
  endfunction

  localparam int FS = fs_of(IQ_W_DEF);

  // LO bit 1 means +1, 0 means -1.
  function automatic int lo_sign(input logic lo_bit, input int value);
    return lo_bit ? value : -value;
  endfunction

endpackage

// File: rtl/sd_mod1.sv
// -----------------------------------------------------------------------------
// sd_mod1
// First-order sigma-delta converting a signed multi-bit stream to 1 bit.
//   clk   in   modulator clock
//   rst   in   asynchronous reset, active-high
//   clr   in   hold the accumulator at 0 and toggle dout (idle pattern)
//   din   in   signed input, IQ_W+2 bits
//   dout  out  1-bit output; +FS feedback when 1, -FS when 0
// -----------------------------------------------------------------------------
import sdr_tx_pkg::*;

module sd_mod1 #(
  parameter int IQ_W  = IQ_W_DEF,
  parameter int ACC_W = IQ_W + 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic signed [IQ_W+1:0] din,
  output logic                   dout
);

  localparam logic signed [ACC_W:0] C_FS = (ACC_W+1)'(fs_of(IQ_W));

  logic signed [ACC_W-1:0] r_acc;
  logic                    r_dout;
  logic signed [ACC_W:0]   w_sum;

  // One guard bit so the decision uses the true sign of acc + din - fb,
  // while the stored accumulator stays within ACC_W.
  assign w_sum = (ACC_W+1)'(r_acc) + (ACC_W+1)'(din) - (r_dout ? C_FS : -C_FS);

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_dout <= 1'b0;
    end else if (clr) begin
      r_acc  <= '0;
      r_dout <= ~r_dout;
    end else begin
      r_acc  <= w_sum[ACC_W-1:0];
      r_dout <= ~w_sum[ACC_W];
    end
  end

  assign dout = r_dout;

endmodule

// File: rtl/iq_tx_modulator.sv
// -----------------------------------------------------------------------------
// iq_tx_modulator
// Accepts baseband I/Q samples over valid/ready, mixes them with a 1-bit
// sin/cos LO (I*cos - Q*sin) and emits a 1-bit RF stream via sigma-delta.
//   clk            in   modulator clock (LO rate)
//   rst            in   asynchronous reset, active-high
//   tx_en          in   transmit enable (level)
//   sample_strobe  in   baseband-rate tick, 1-clk pulse
//   iq_valid       in   producer has a sample
//   iq_ready       out  sample accepted this clk when iq_valid is high
//   i_in, q_in     in   signed I/Q samples
//   sin_in,cos_in  in   LO bits (1 => +1, 0 => -1)
//   RFOut          out  1-bit RF output
//   busy           out  FSM not in IDLE
//   underrun_cnt   out  saturating count of strobes with no sample in RUN
// -----------------------------------------------------------------------------
import sdr_tx_pkg::*;

module iq_tx_modulator #(
  parameter int IQ_W       = 8,
  parameter int ACC_W      = IQ_W + 3,
  parameter int UNDERRUN_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tx_en,
  input  logic                    sample_strobe,
  input  logic                    iq_valid,
  output logic                    iq_ready,
  input  logic signed [IQ_W-1:0]  i_in,
  input  logic signed [IQ_W-1:0]  q_in,
  input  logic                    sin_in,
  input  logic                    cos_in,
  output logic                    RFOut,
  output logic                    busy,
  output logic [UNDERRUN_W-1:0]   underrun_cnt
);

  localparam int MIX_W = IQ_W + 2;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_nxt_full;
  logic signed [IQ_W-1:0]   r_nxt_i;
  logic signed [IQ_W-1:0]   r_nxt_q;
  logic signed [IQ_W-1:0]   r_cur_i;
  logic signed [IQ_W-1:0]   r_cur_q;
  logic signed [MIX_W-1:0]  r_mix;
  logic [UNDERRUN_W-1:0]    r_underrun;
  logic                     w_xfer;
  logic                     w_clr;
  logic                     w_underrun;

  assign w_xfer = iq_valid & iq_ready;
  // Clearing follows tx_en directly so the pipeline empties on the same edge
  // that returns the FSM to IDLE, and stays empty while idle.
  assign w_clr  = ~tx_en | (r_state == IDLE);
  assign w_underrun = tx_en & (r_state == RUN) & sample_strobe & ~r_nxt_full & ~w_xfer;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: default assigned first so no path through the case infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (!tx_en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = FILL;
        FILL:    if (r_nxt_full && sample_strobe) w_state_nxt = RUN;
        RUN:     w_state_nxt = RUN;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Ready depends on registered state only, never on iq_valid.
  always_comb begin
    busy     = (r_state != IDLE);
    iq_ready = (r_state != IDLE) && !r_nxt_full;
  end

  // ---------------------------------------------------------- nxt / cur
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nxt_full <= 1'b0;
      r_nxt_i    <= '0;
      r_nxt_q    <= '0;
      r_cur_i    <= '0;
      r_cur_q    <= '0;
    end else if (!tx_en) begin
      r_nxt_full <= 1'b0;
      r_cur_i    <= '0;
      r_cur_q    <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_xfer) begin
            r_nxt_i    <= i_in;
            r_nxt_q    <= q_in;
            r_nxt_full <= 1'b1;
          end
          // Transfer and this load are exclusive: a transfer needs nxt empty.
          if (r_nxt_full && sample_strobe) begin
            r_cur_i    <= r_nxt_i;
            r_cur_q    <= r_nxt_q;
            r_nxt_full <= 1'b0;
          end
        end
        RUN: begin
          if (sample_strobe) begin
            if (r_nxt_full) begin
              r_cur_i    <= r_nxt_i;
              r_cur_q    <= r_nxt_q;
              r_nxt_full <= 1'b0;
            end else if (w_xfer) begin
              // Sample arriving on the strobe bypasses nxt.
              r_cur_i <= i_in;
              r_cur_q <= q_in;
            end else begin
              r_cur_i <= '0;
              r_cur_q <= '0;
            end
          end else if (w_xfer) begin
            r_nxt_i    <= i_in;
            r_nxt_q    <= q_in;
            r_nxt_full <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ----------------------------------------------------- underrun count
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_underrun <= '0;
    else if (w_underrun && (r_underrun != '1))
      r_underrun <= r_underrun + UNDERRUN_W'(1);
  end

  assign underrun_cnt = r_underrun;

  // -------------------------------------------------------------- mixer
  // Operands are widened to int before negation so -(-2**(IQ_W-1)) is exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_mix <= '0;
    else if (w_clr)
      r_mix <= '0;
    else
      r_mix <= MIX_W'(lo_sign(cos_in, int'(r_cur_i)) - lo_sign(sin_in, int'(r_cur_q)));
  end

  // -------------------------------------------------------- sigma-delta
  sd_mod1 #(
    .IQ_W  (IQ_W),
    .ACC_W (ACC_W)
  ) u_sd (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .din  (r_mix),
    .dout (RFOut)
  );

endmodule

// File: tb/tb_iq_tx_modulator.sv
import sdr_tx_pkg::*;

module tb_iq_tx_modulator;

  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_RUN  = 2;
  localparam int FULL   = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              tx_en;
  logic              sample_strobe;
  logic              iq_valid;
  logic signed [7:0] i_in;
  logic signed [7:0] q_in;
  logic              sin_in;
  logic              cos_in;
  logic              iq_ready;
  logic              RFOut;
  logic              busy;
  logic [15:0]       underrun_cnt;
  logic              iq_ready4;
  logic              rf4;
  logic              busy4;
  logic [3:0]        und4;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit auto_strobe = 1'b0;

  // Behavioural model state (plain integers)
  int m_st, m_nf, m_nxt_i, m_nxt_q, m_cur_i, m_cur_q, m_mix, m_acc, m_rf, m_und, m_und4;

  iq_tx_modulator dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .sample_strobe(sample_strobe),
    .iq_valid(iq_valid), .iq_ready(iq_ready), .i_in(i_in), .q_in(q_in),
    .sin_in(sin_in), .cos_in(cos_in), .RFOut(RFOut), .busy(busy),
    .underrun_cnt(underrun_cnt)
  );

  iq_tx_modulator #(.UNDERRUN_W(4)) dut4 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .sample_strobe(sample_strobe),
    .iq_valid(iq_valid), .iq_ready(iq_ready4), .i_in(i_in), .q_in(q_in),
    .sin_in(sin_in), .cos_in(cos_in), .RFOut(rf4), .busy(busy4),
    .underrun_cnt(und4)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int lo(input logic b, input int v);
    return b ? v : -v;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_nf = 0; m_nxt_i = 0; m_nxt_q = 0; m_cur_i = 0; m_cur_q = 0;
    m_mix = 0; m_acc = 0; m_rf = 0; m_und = 0; m_und4 = 0;
  endtask

  // Advances the model across one rising edge using the inputs now applied.
  task automatic model_step();
    int ii, qq, a;
    bit ready, xfer, clr;
    int st_n, nf_n, nxi, nxq, ci, cq, mix_n, acc_n, rf_n, und_n, und4_n;
    ii = int'(i_in);
    qq = int'(q_in);
    ready = (m_st != M_IDLE) && (m_nf == 0);
    xfer  = iq_valid && ready;
    clr   = !tx_en || (m_st == M_IDLE);
    st_n = m_st; nf_n = m_nf; nxi = m_nxt_i; nxq = m_nxt_q; ci = m_cur_i; cq = m_cur_q;
    und_n = m_und; und4_n = m_und4;
    if (clr) begin
      acc_n = 0; rf_n = 1 - m_rf; mix_n = 0;
    end else begin
      a = m_acc + m_mix - (m_rf != 0 ? FULL : -FULL);
      acc_n = a;
      rf_n  = (a >= 0) ? 1 : 0;
      mix_n = lo(cos_in, m_cur_i) - lo(sin_in, m_cur_q);
    end
    if (!tx_en) begin
      st_n = M_IDLE; nf_n = 0; ci = 0; cq = 0;
    end else if (m_st == M_IDLE) begin
      st_n = M_FILL;
    end else if (m_st == M_FILL) begin
      if (xfer) begin nxi = ii; nxq = qq; nf_n = 1; end
      if (m_nf != 0 && sample_strobe) begin
        ci = m_nxt_i; cq = m_nxt_q; nf_n = 0; st_n = M_RUN;
      end
    end else begin
      if (sample_strobe) begin
        if (m_nf != 0) begin ci = m_nxt_i; cq = m_nxt_q; nf_n = 0; end
        else if (xfer) begin ci = ii; cq = qq; end
        else begin
          ci = 0; cq = 0;
          if (m_und < 65535) und_n = m_und + 1;
          if (m_und4 < 15) und4_n = m_und4 + 1;
        end
      end else if (xfer) begin
        nxi = ii; nxq = qq; nf_n = 1;
      end
    end
    m_st = st_n; m_nf = nf_n; m_nxt_i = nxi; m_nxt_q = nxq; m_cur_i = ci; m_cur_q = cq;
    m_mix = mix_n; m_acc = acc_n; m_rf = rf_n; m_und = und_n; m_und4 = und4_n;
  endtask

  // One clock: model follows the edge, outputs are then sampled at negedge.
  task automatic step();
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
    cyc++;
    if (auto_strobe) sample_strobe = ((cyc % 16) == 0);
  endtask

  task automatic strobe_pulse();
    sample_strobe = 1'b1;
    step();
    sample_strobe = 1'b0;
    step();
    step();
  endtask

  // ------------------------------------------------------------------
  task automatic test_reset();
    int prev;
    #1;
    n_checks++; if (RFOut !== 1'b0) $display("FAIL reset_rf: got %b expected 0", RFOut); else n_pass++;
    n_checks++; if (iq_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", iq_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (underrun_cnt !== 16'd0) $display("FAIL reset_underrun: got %0d expected 0", underrun_cnt); else n_pass++;
    step();
    step();
    rst = 1'b0;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (RFOut !== 1'(1 - prev)) $display("FAIL idle_toggle: got %b expected %0d", RFOut, 1 - prev);
      else n_pass++;
      prev = 1 - prev;
    end
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    for (int k = 0; k < n; k++) begin
      step();
      ones += int'(RFOut);
    end
  endtask

  task automatic test_zero_stream();
    int ones;
    tx_en = 1'b1; iq_valid = 1'b1; i_in = 8'sd0; q_in = 8'sd0; cos_in = 1'b1; sin_in = 1'b0;
    auto_strobe = 1'b1;
    step();
    n_checks++; if (busy !== 1'b1) $display("FAIL busy_after_en: got %b expected 1", busy); else n_pass++;
    for (int k = 0; k < 64; k++) step();
    count_ones(1024, ones);
    n_checks++;
    if (ones < 510 || ones > 514) $display("FAIL zero_density: got %0d expected 512+/-2", ones);
    else n_pass++;
    n_checks++; if (underrun_cnt !== 16'd0) $display("FAIL zero_underrun: got %0d expected 0", underrun_cnt); else n_pass++;
  endtask

  task automatic test_density(input int iv, input int qv, input bit c, input bit s);
    int ones, mix, expv;
    i_in = 8'(iv); q_in = 8'(qv); cos_in = c; sin_in = s;
    mix  = (c ? iv : -iv) - (s ? qv : -qv);
    expv = (1024 * (FULL + mix)) / (2 * FULL);
    for (int k = 0; k < 48; k++) step();
    count_ones(1024, ones);
    n_checks++;
    if (ones < expv - 2 || ones > expv + 2)
      $display("FAIL density I=%0d Q=%0d cos=%b sin=%b: got %0d expected %0d+/-2", iv, qv, c, s, ones, expv);
    else n_pass++;
  endtask

  task automatic test_underrun();
    auto_strobe = 1'b0;
    sample_strobe = 1'b0;
    step();
    step();
    iq_valid = 1'b0;
    strobe_pulse();
    for (int k = 0; k < 5; k++) strobe_pulse();
    n_checks++; if (underrun_cnt !== 16'd5) $display("FAIL underrun_5: got %0d expected 5", underrun_cnt); else n_pass++;
    n_checks++; if (und4 !== 4'd5) $display("FAIL underrun4_5: got %0d expected 5", und4); else n_pass++;
    n_checks++; if (dut.r_cur_i !== 8'sd0) $display("FAIL underrun_cur_i: got %0d expected 0", dut.r_cur_i); else n_pass++;
    n_checks++; if (dut.r_cur_q !== 8'sd0) $display("FAIL underrun_cur_q: got %0d expected 0", dut.r_cur_q); else n_pass++;
    for (int k = 0; k < 15; k++) strobe_pulse();
    n_checks++; if (underrun_cnt !== 16'd20) $display("FAIL underrun_20: got %0d expected 20", underrun_cnt); else n_pass++;
    n_checks++; if (und4 !== 4'd15) $display("FAIL underrun4_sat: got %0d expected 15", und4); else n_pass++;
  endtask

  task automatic test_bypass_and_backpressure();
    logic signed [7:0] qv;
    qv = 8'($urandom_range(0, 255));
    iq_valid = 1'b1; i_in = 8'sh40; q_in = qv; sample_strobe = 1'b1;
    step();
    sample_strobe = 1'b0;
    n_checks++; if (dut.r_cur_i !== 8'sh40) $display("FAIL bypass_cur_i: got %0d expected 64", dut.r_cur_i); else n_pass++;
    n_checks++; if (dut.r_cur_q !== qv) $display("FAIL bypass_cur_q: got %0d expected %0d", dut.r_cur_q, qv); else n_pass++;
    n_checks++; if (dut.r_nxt_full !== 1'b0) $display("FAIL bypass_nxt_full: got %b expected 0", dut.r_nxt_full); else n_pass++;
    n_checks++; if (underrun_cnt !== 16'd20) $display("FAIL bypass_underrun: got %0d expected 20", underrun_cnt); else n_pass++;
    i_in = 8'sh11;
    step();
    n_checks++; if (iq_ready !== 1'b0) $display("FAIL bp_ready: got %b expected 0", iq_ready); else n_pass++;
    n_checks++; if (dut.r_nxt_i !== 8'sh11) $display("FAIL bp_nxt_load: got %0d expected 17", dut.r_nxt_i); else n_pass++;
    i_in = 8'sh22;
    for (int k = 0; k < 3; k++) step();
    n_checks++; if (iq_ready !== 1'b0) $display("FAIL bp_ready_held: got %b expected 0", iq_ready); else n_pass++;
    n_checks++; if (dut.r_nxt_i !== 8'sh11) $display("FAIL bp_no_overwrite: got %0d expected 17", dut.r_nxt_i); else n_pass++;
    strobe_pulse();
    n_checks++; if (dut.r_cur_i !== 8'sh11) $display("FAIL bp_cur_from_nxt: got %0d expected 17", dut.r_cur_i); else n_pass++;
  endtask

  task automatic test_disable();
    logic prev;
    tx_en = 1'b0; iq_valid = 1'b0;
    step();
    n_checks++; if (busy !== 1'b0) $display("FAIL dis_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (iq_ready !== 1'b0) $display("FAIL dis_ready: got %b expected 0", iq_ready); else n_pass++;
    n_checks++; if (dut.r_state !== IDLE) $display("FAIL dis_state: got %0d expected %0d", dut.r_state, IDLE); else n_pass++;
    n_checks++; if (dut.r_nxt_full !== 1'b0) $display("FAIL dis_nxt_full: got %b expected 0", dut.r_nxt_full); else n_pass++;
    n_checks++; if (dut.r_cur_i !== 8'sd0) $display("FAIL dis_cur_i: got %0d expected 0", dut.r_cur_i); else n_pass++;
    n_checks++; if (underrun_cnt !== 16'd20) $display("FAIL dis_underrun: got %0d expected 20", underrun_cnt); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      prev = RFOut;
      step();
      n_checks++; if (RFOut !== ~prev) $display("FAIL dis_toggle: got %b expected %b", RFOut, ~prev); else n_pass++;
    end
  endtask

  task automatic test_random();
    auto_strobe = 1'b0;
    for (int k = 0; k < 800; k++) begin
      tx_en         = ($urandom_range(0, 39) != 0);
      sample_strobe = ($urandom_range(0, 7) == 0);
      iq_valid      = ($urandom_range(0, 2) == 0);
      i_in          = 8'($urandom_range(0, 255));
      q_in          = 8'($urandom_range(0, 255));
      sin_in        = 1'($urandom_range(0, 1));
      cos_in        = 1'($urandom_range(0, 1));
      step();
      n_checks++; if (iq_ready !== 1'((m_st != M_IDLE) && (m_nf == 0))) $display("FAIL rnd_ready cyc=%0d: got %b expected %0d", cyc, iq_ready, (m_st != M_IDLE) && (m_nf == 0)); else n_pass++;
      n_checks++; if (busy !== 1'(m_st != M_IDLE)) $display("FAIL rnd_busy cyc=%0d: got %b expected %0d", cyc, busy, m_st != M_IDLE); else n_pass++;
      n_checks++; if (RFOut !== 1'(m_rf)) $display("FAIL rnd_rf cyc=%0d: got %b expected %0d", cyc, RFOut, m_rf); else n_pass++;
      n_checks++; if (underrun_cnt !== 16'(m_und)) $display("FAIL rnd_underrun cyc=%0d: got %0d expected %0d", cyc, underrun_cnt, m_und); else n_pass++;
      n_checks++; if (und4 !== 4'(m_und4)) $display("FAIL rnd_underrun4 cyc=%0d: got %0d expected %0d", cyc, und4, m_und4); else n_pass++;
    end
  endtask

  task automatic test_async_reset_mid_run();
    tx_en = 1'b1; iq_valid = 1'b1; i_in = 8'sd90; q_in = -8'sd30; cos_in = 1'b1; sin_in = 1'b1;
    sample_strobe = 1'b0;
    auto_strobe = 1'b1;
    for (int k = 0; k < 40; k++) step();
    n_checks++; if (busy !== 1'b1) $display("FAIL pre_reset_busy: got %b expected 1", busy); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (RFOut !== 1'b0) $display("FAIL async_rf: got %b expected 0", RFOut); else n_pass++;
    n_checks++; if (iq_ready !== 1'b0) $display("FAIL async_ready: got %b expected 0", iq_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL async_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (underrun_cnt !== 16'd0) $display("FAIL async_underrun: got %0d expected 0", underrun_cnt); else n_pass++;
    n_checks++; if (und4 !== 4'd0) $display("FAIL async_underrun4: got %0d expected 0", und4); else n_pass++;
    n_checks++; if (dut.r_state !== IDLE) $display("FAIL async_state: got %0d expected %0d", dut.r_state, IDLE); else n_pass++;
    auto_strobe = 1'b0;
    sample_strobe = 1'b0;
    tx_en = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (RFOut !== 1'(m_rf)) $display("FAIL post_reset_rf: got %b expected %0d", RFOut, m_rf); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; tx_en = 1'b0; sample_strobe = 1'b0; iq_valid = 1'b0;
    i_in = '0; q_in = '0; sin_in = 1'b0; cos_in = 1'b1;
    model_reset();
    test_reset();
    test_zero_stream();
    test_density(127, 0, 1'b1, 1'b0);
    test_density(-128, 0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++)
      test_density($urandom_range(0, 200) - 100, $urandom_range(0, 200) - 100,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    test_underrun();
    test_bypass_and_backpressure();
    test_disable();
    test_random();
    test_async_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
